// File: rtl/seq_alu_if.sv
// seq_alu_if: operation request/result bundle; master issues ops, slave is the ALU
interface seq_alu_if;
  logic       i_start;
  logic [2:0] i_op;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_result;
  logic [7:0] o_result_hi;
  logic [3:0] o_flags;
  logic       o_fwe;
  modport master (output i_start, i_op, i_a, i_b, input o_busy, o_done, o_result, o_result_hi, o_flags, o_fwe);
  modport slave (input i_start, i_op, i_a, i_b, output o_busy, o_done, o_result, o_result_hi, o_flags, o_fwe);
endinterface

// File: rtl/seq_alu.sv
// seq_alu: 8-bit sequential ALU (ports: i_clk, i_rst_n async low, bus = start/op/a/b in, busy/done/result/result_hi/flags{CF,OF,NF,ZF}/fwe out)
module seq_alu (
  input logic     i_clk,
  input logic     i_rst_n,
  seq_alu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_op, r_cnt;
  logic [7:0]  r_a, r_b, r_result, r_result_hi;
  logic [3:0]  r_flags, w_flags;
  logic [15:0] r_acc, w_pp, w_acc;
  logic [8:0]  w_res;
  logic        w_of, w_busy, w_done;
  always_comb begin
    w_next = IDLE;
    w_busy = r_state != IDLE;
    w_done = r_state == DONE;
    w_next = r_state == IDLE ? (bus.i_start ? (bus.i_op == 3'b111 ? MUL : EXEC) : IDLE) :
             r_state == EXEC ? DONE :
             r_state == MUL  ? (r_cnt == 3'd7 ? DONE : MUL) : IDLE;
  end
  // bit 8 of w_res is the carry/borrow/shifted-out bit, so CF falls out directly
  always_comb begin
    w_res = r_op == 3'd0 ? {1'b0, r_a} + {1'b0, r_b} :
            r_op == 3'd1 ? {1'b0, r_a} - {1'b0, r_b} :
            r_op == 3'd2 ? {1'b0, r_a & r_b} :
            r_op == 3'd3 ? {1'b0, r_a | r_b} :
            r_op == 3'd4 ? {1'b0, r_a ^ r_b} :
            r_op == 3'd5 ? {r_a, 1'b0} :
            r_op == 3'd6 ? {r_a[0], 1'b0, r_a[7:1]} : 9'h000;
    w_of = r_op == 3'd0 ? (r_a[7] == r_b[7]) && (w_res[7] != r_a[7]) :
           r_op == 3'd1 ? (r_a[7] != r_b[7]) && (w_res[7] != r_a[7]) :
           r_op == 3'd5 ? r_a[7] ^ r_a[6] : 1'b0;
    w_flags = {w_res[8], w_of, w_res[7], w_res[7:0] == 8'h00};
    w_pp = r_b[r_cnt] ? ({8'h00, r_a} << r_cnt) : 16'h0000;
    w_acc = r_acc + w_pp;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.i_start) begin
        r_op  <= bus.i_op;
        r_a   <= bus.i_a;
        r_b   <= bus.i_b;
        r_cnt <= '0;
        r_acc <= '0;
      end
      if (r_state == EXEC) begin
        r_result    <= w_res[7:0];
        r_result_hi <= 8'h00;
        r_flags     <= w_flags;
      end
      if (r_state == MUL) begin
        r_acc <= w_acc;
        r_cnt <= r_cnt + 3'd1;
      end
      if (r_state == MUL && r_cnt == 3'd7) begin
        r_result    <= w_acc[7:0];
        r_result_hi <= w_acc[15:8];
        r_flags     <= {|w_acc[15:8], |w_acc[15:8], w_acc[15], w_acc == 16'h0000};
      end
    end
  end
  assign bus.o_busy      = w_busy;
  assign bus.o_done      = w_done;
  assign bus.o_fwe       = w_done;
  assign bus.o_result    = r_result;
  assign bus.o_result_hi = r_result_hi;
  assign bus.o_flags     = r_flags;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu against an arithmetic reference model
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  seq_alu_if bus ();
  seq_alu dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] res, output logic [7:0] hi, output logic [3:0] fl);
    int ia, ib, sa, sb, s, ss, p;
    bit cf, of, nf, zf;
    ia = a; ib = b; sa = $signed(a); sb = $signed(b);
    cf = 0; of = 0; hi = 8'h00; s = 0;
    case (op)
      3'd0: begin s = ia + ib; ss = sa + sb; cf = s > 255; of = ss > 127 || ss < -128; end
      3'd1: begin s = ia - ib; ss = sa - sb; cf = ia < ib; of = ss > 127 || ss < -128; end
      3'd2: s = ia & ib;
      3'd3: s = ia | ib;
      3'd4: s = ia ^ ib;
      3'd5: begin s = ia * 2; cf = ia >= 128; of = (ia >= 128) != ((ia % 128) >= 64); end
      3'd6: begin s = ia / 2; cf = (ia % 2) == 1; end
      default: s = 0;
    endcase
    res = 8'(s);
    nf = (s & 128) != 0;
    zf = res == 8'h00;
    if (op == 3'd7) begin
      p = ia * ib;
      res = 8'(p % 256);
      hi = 8'(p / 256);
      cf = hi != 0; of = cf; nf = p >= 32768; zf = p == 0;
    end
    fl = {cf, of, nf, zf};
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] er, eh;
    logic [3:0] ef;
    int lat;
    bit busy_ok;
    model(op, a, b, er, eh, ef);
    @(negedge clk);
    chk("idle_busy", 16'(bus.o_busy), 16'h0);
    bus.i_start = 1'b1; bus.i_op = op; bus.i_a = a; bus.i_b = b;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_op = 3'($urandom); bus.i_a = 8'($urandom); bus.i_b = 8'($urandom);
    lat = 0; busy_ok = 1;
    while (!bus.o_done && lat < 20) begin
      busy_ok &= bus.o_busy;
      @(negedge clk);
      lat++;
    end
    chk("busy_during_op", 16'(busy_ok), 16'h1);
    chk("latency", 16'(lat), op == 3'd7 ? 16'd8 : 16'd1);
    chk("busy_in_done", 16'(bus.o_busy), 16'h1);
    chk("fwe_in_done", 16'(bus.o_fwe), 16'h1);
    chk("result", 16'(bus.o_result), 16'(er));
    chk("result_hi", 16'(bus.o_result_hi), 16'(eh));
    chk("flags", 16'(bus.o_flags), 16'(ef));
    @(negedge clk);
    chk("done_pulse_end", 16'({bus.o_done, bus.o_fwe, bus.o_busy}), 16'h0);
    chk("result_held", 16'({bus.o_result_hi, bus.o_result}), 16'({eh, er}));
    chk("flags_held", 16'(bus.o_flags), 16'(ef));
  endtask

  initial begin
    logic [7:0] er, eh, cap_r, cap_h;
    logic [3:0] ef, cap_f;
    int ndone, dlat, first, last;
    bus.i_start = 1'b0; bus.i_op = '0; bus.i_a = '0; bus.i_b = '0;
    #1;
    chk("reset_outputs", 16'({bus.o_busy, bus.o_done, bus.o_fwe, bus.o_flags}), 16'h0);
    chk("reset_result", 16'({bus.o_result_hi, bus.o_result}), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 8'h7F, 8'h01);
    run_op(3'd1, 8'h00, 8'h01);
    run_op(3'd0, 8'h05, 8'hFB);
    run_op(3'd7, 8'h10, 8'h10);
    run_op(3'd7, 8'hFF, 8'hFF);
    run_op(3'd5, 8'h40, 8'h00);
    run_op(3'd4, 8'hA5, 8'hA5);
    run_op(3'd6, 8'h81, 8'h00);
    run_op(3'd7, 8'h00, 8'h37);
    // START held through a MUL while the op/operands churn
    model(3'd7, 8'h13, 8'h2D, er, eh, ef);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = 3'd7; bus.i_a = 8'h13; bus.i_b = 8'h2D;
    @(negedge clk);
    ndone = 0; dlat = 0; cap_r = 0; cap_h = 0; cap_f = 0;
    for (int i = 1; i <= 12; i++) begin
      bus.i_op = 3'($urandom); bus.i_a = 8'($urandom); bus.i_b = 8'($urandom);
      @(negedge clk);
      if (bus.o_done) begin
        ndone++; dlat = i;
        cap_r = bus.o_result; cap_h = bus.o_result_hi; cap_f = bus.o_flags;
        bus.i_start = 1'b0;
      end
    end
    chk("hold_done_count", 16'(ndone), 16'd1);
    chk("hold_mul_latency", 16'(dlat), 16'd8);
    chk("hold_mul_product", 16'({cap_h, cap_r}), 16'({eh, er}));
    chk("hold_mul_flags", 16'(cap_f), 16'(ef));
    // back-to-back ADDs with START held: one completion every 3 cycles
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = 3'd0; bus.i_a = 8'h11; bus.i_b = 8'h22;
    ndone = 0; first = 0; last = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (bus.o_done) begin
        ndone++; last = i;
        if (first == 0) first = i;
      end
    end
    bus.i_start = 1'b0;
    chk("b2b_done_count", 16'(ndone), 16'd3);
    chk("b2b_first_done", 16'(first), 16'd2);
    chk("b2b_last_done", 16'(last), 16'd8);
    chk("b2b_result", 16'(bus.o_result), 16'h33);
    repeat (3) @(negedge clk);
    chk("b2b_idle", 16'(bus.o_busy), 16'h0);
    // reset in the middle of a MUL (counter = 4)
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = 3'd7; bus.i_a = 8'hFF; bus.i_b = 8'hFF;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", 16'(bus.o_busy), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", 16'({bus.o_busy, bus.o_done, bus.o_fwe}), 16'h0);
    chk("abort_result", 16'({bus.o_result_hi, bus.o_result}), 16'h0);
    chk("abort_flags", 16'(bus.o_flags), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.o_done || bus.o_fwe) ndone++;
    end
    chk("abort_no_done", 16'(ndone), 16'd0);
    run_op(3'd6, 8'h01, 8'h00);
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
